// File: rtl/seg_scan_multi.sv
// Multiplexed seven-segment scanner: configurable digit count and scan rate,
// frame-coherent snapshot with hold/load, leading-zero suppression, blanking and anode dead time.
module seg_scan_multi #(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int GHOST_CYCLES   = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       data_i,
  input  logic [NUM_DIGITS-1:0]         dp_i,
  input  logic [NUM_DIGITS-1:0]         blank_i,
  input  logic                          lzs_en_i,
  input  logic                          hold_i,
  input  logic                          load_i,
  output logic [7:0]                    seg_o,
  output logic [NUM_DIGITS-1:0]         an_o,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
  output logic                          frame_tick_o
);

  localparam int DW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  if (NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_bad_digits
    $error("seg_scan_multi: NUM_DIGITS must be 2..16");
  end
  if (SCAN_DIV < 2) begin : g_bad_div
    $error("seg_scan_multi: SCAN_DIV must be >= 2");
  end
  if (GHOST_CYCLES < 0 || GHOST_CYCLES >= SCAN_DIV) begin : g_bad_ghost
    $error("seg_scan_multi: GHOST_CYCLES must be in 0..SCAN_DIV-1");
  end

  logic [PW-1:0]         prescaler;
  logic [DW-1:0]         digit_idx;
  logic [3:0]            snap_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] snap_dp;
  logic [NUM_DIGITS-1:0] snap_blank;
  logic                  frame_start_q;

  logic                  wrap;
  logic                  frame_start;
  logic                  capture;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic [7:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign wrap        = (prescaler == PW'(SCAN_DIV - 1));
  assign frame_start = wrap && (digit_idx == DW'(NUM_DIGITS - 1));
  assign capture     = load_i || (frame_start && !hold_i);

  // lead_zero[k]: snapshot nibbles k..NUM_DIGITS-1 are all zero
  always_comb begin
    logic run;
    lead_zero = '0;
    run       = 1'b1;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      run = run && (snap_nib[NUM_DIGITS-1-j] == 4'h0);
      lead_zero[NUM_DIGITS-1-j] = run;
    end
  end

  always_comb begin
    seg_next = {snap_dp[digit_idx], hex7(snap_nib[digit_idx])};
    if (lzs_en_i && (digit_idx != '0) && lead_zero[digit_idx])
      seg_next[6:0] = '0;
    if (snap_blank[digit_idx])
      seg_next = '0;
  end

  always_comb begin
    an_next = '0;
    if (prescaler >= PW'(GHOST_CYCLES))
      an_next[digit_idx] = 1'b1;
  end

  // Outputs are registered from the current scan state, so frame_tick is
  // delayed twice to line up with digit_idx_o returning to 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescaler     <= '0;
      digit_idx     <= '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++)
        snap_nib[k] <= '0;
      snap_dp       <= '0;
      snap_blank    <= '0;
      frame_start_q <= 1'b0;
      frame_tick_o  <= 1'b0;
      seg_o         <= SEG_OFF;
      an_o          <= AN_OFF;
      digit_idx_o   <= '0;
    end else begin
      if (wrap) begin
        prescaler <= '0;
        digit_idx <= (digit_idx == DW'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      if (capture) begin
        for (int unsigned k = 0; k < NUM_DIGITS; k++)
          snap_nib[k] <= data_i[4*k +: 4];
        snap_dp    <= dp_i;
        snap_blank <= blank_i;
      end
      frame_start_q <= frame_start;
      frame_tick_o  <= frame_start_q;
      seg_o         <= (SEG_ACTIVE_LOW != 0) ? ~seg_next : seg_next;
      an_o          <= (AN_ACTIVE_LOW != 0) ? ~an_next : an_next;
      digit_idx_o   <= digit_idx;
    end
  end

endmodule

// File: tb/tb_seg_scan_multi.sv
// Scoreboard bench for seg_scan_multi: expected per-slot segment/anode values are
// queued per frame and checked at the first lit cycle of each digit slot.
module tb_seg_scan_multi;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_i;
  logic [7:0]  dp_i;
  logic [7:0]  blank_i;
  logic        lzs_en_i;
  logic        hold_i;
  logic        load_i;
  logic [7:0]  seg_o;
  logic [7:0]  an_o;
  logic [2:0]  digit_idx_o;
  logic        frame_tick_o;

  always #5 clock = ~clock;

  seg_scan_multi #(
    .NUM_DIGITS(8), .SCAN_DIV(4), .GHOST_CYCLES(1),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clock(clock), .reset(reset), .data_i(data_i), .dp_i(dp_i),
    .blank_i(blank_i), .lzs_en_i(lzs_en_i), .hold_i(hold_i), .load_i(load_i),
    .seg_o(seg_o), .an_o(an_o), .digit_idx_o(digit_idx_o), .frame_tick_o(frame_tick_o)
  );

  typedef struct packed {
    logic [2:0] d;
    logic [7:0] seg;
    logic [7:0] an;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] prev_an = 8'hFF;

  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset === 1'b1 && an_o !== 8'hFF && prev_an === 8'hFF && sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if ({digit_idx_o, seg_o, an_o} !== e) begin
        failures++;
        $display("FAIL slot: got digit=%0d seg=%h an=%h, expected digit=%0d seg=%h an=%h",
                 digit_idx_o, seg_o, an_o, e.d, e.seg, e.an);
      end
    end
    prev_an = an_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (frame_tick_o) return;
    end
    timeout("frame_tick");
  endtask

  task automatic apply(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl,
                       input logic lzs);
    @(negedge clock);
    data_i = d; dp_i = dp; blank_i = bl; lzs_en_i = lzs; load_i = 1'b1;
    @(negedge clock);
    load_i = 1'b0;
  endtask

  // exp holds the active-low seg byte for digit k at exp[8k+:8]
  task automatic push_frame(input logic [63:0] exp);
    exp_t e;
    wait_tick();
    for (int k = 0; k < 8; k++) begin
      e.d   = 3'(k);
      e.seg = exp[8*k +: 8];
      e.an  = ~(8'h01 << k);
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (sbq.size() == 0) return;
      @(negedge clock);
    end
    timeout("scoreboard drain");
    sbq.delete();
  endtask

  task automatic wait_slot(input logic [2:0] d);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (digit_idx_o == d && an_o != 8'hFF) return;
    end
    timeout("wait_slot");
  endtask

  initial begin
    logic [71:0] an_seq;
    int n;
    reset = 1'b0; data_i = '0; dp_i = '0; blank_i = '0;
    lzs_en_i = 1'b0; hold_i = 1'b0; load_i = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset seg", 32'(seg_o), 32'hFF);
    chk("reset an", 32'(an_o), 32'hFF);
    chk("reset digit", 32'(digit_idx_o), 32'h0);
    chk("reset tick", 32'(frame_tick_o), 32'h0);

    reset = 1'b1;
    an_seq = 72'hFF_FE_FE_FE_FF_FD_FD_FD_FF;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      chk("scan an", 32'(an_o), 32'(an_seq[8*(8-i) +: 8]));
    end

    wait_tick();
    chk("tick digit", 32'(digit_idx_o), 32'h0);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!frame_tick_o && n < 100);
    chk("frame period", 32'(n), 32'd32);

    apply(32'h89ABCDEF, 8'h00, 8'h00, 1'b0);
    push_frame(64'h80_90_88_83_C6_A1_86_8E); drain();
    apply(32'h01234567, 8'h00, 8'h00, 1'b0);
    push_frame(64'hC0_F9_A4_B0_99_92_82_F8); drain();

    apply(32'h00000050, 8'h80, 8'h00, 1'b1);
    push_frame(64'h7F_FF_FF_FF_FF_FF_92_C0); drain();
    apply(32'h00000000, 8'h00, 8'h00, 1'b1);
    push_frame(64'hFF_FF_FF_FF_FF_FF_FF_C0); drain();
    apply(32'h00102000, 8'h01, 8'h00, 1'b1);
    push_frame(64'hFF_FF_F9_C0_A4_C0_C0_40); drain();

    apply(32'h89ABCDEF, 8'h01, 8'h0F, 1'b0);
    push_frame(64'h80_90_88_83_FF_FF_FF_FF); drain();

    apply(32'h11111111, 8'h00, 8'h00, 1'b0);
    hold_i = 1'b1;
    data_i = 32'h22222222;
    for (int f = 0; f < 3; f++) begin
      push_frame(64'hF9F9F9F9_F9F9F9F9); drain();
    end
    push_frame(64'hA4A4A4A4_F9F9F9F9);
    wait_slot(3'd3);
    load_i = 1'b1;
    @(negedge clock);
    load_i = 1'b0;
    drain();
    hold_i = 1'b0;

    wait_slot(3'd5);
    reset = 1'b0;
    #1;
    chk("async reset an", 32'(an_o), 32'hFF);
    chk("async reset seg", 32'(seg_o), 32'hFF);
    chk("async reset digit", 32'(digit_idx_o), 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (an_o == 8'hFF && n < 10);
    chk("restart latency", 32'(n), 32'd2);
    chk("restart an", 32'(an_o), 32'hFE);
    chk("restart digit", 32'(digit_idx_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
